// File: rtl/novaedge_pkg.sv
// Shared NovaEdge32 branch definitions: funct3 codes, FSM encoding, taken decode.
package novaedge_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reserved codes (010/011) never take the branch.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic gt);
    logic t;
    case (f3)
      F3_BEQ:            t = eq;
      F3_BNE:            t = ~eq;
      F3_BLT, F3_BLTU:   t = lt;
      F3_BGE, F3_BGEU:   t = eq | gt;
      default:           t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_compare_unit_if.sv
// Request/response bundle between operand-forwarding, the branch resolver and PC redirect.
interface branch_compare_unit_if #(parameter int unsigned XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [2:0]      funct3_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic            taken_o;
  logic            eq_o;
  logic            lt_o;
  logic            gt_o;
  logic            illegal_o;

  modport slave (
    input  in_valid_i, rs1_i, rs2_i, funct3_i, out_ready_i,
    output in_ready_o, out_valid_o, taken_o, eq_o, lt_o, gt_o, illegal_o
  );

  modport master (
    output in_valid_i, rs1_i, rs2_i, funct3_i, out_ready_i,
    input  in_ready_o, out_valid_o, taken_o, eq_o, lt_o, gt_o, illegal_o
  );
endinterface

// File: rtl/nibble_cmp4.sv
// 4-bit magnitude comparator; sign mode flips the MSBs so two's-complement orders correctly.
module nibble_cmp4 (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       sign_i,
  output logic       equal_o,
  output logic       greater_o,
  output logic       less_o
);
  logic [3:0] xa;
  logic [3:0] ya;

  assign xa        = {x_i[3] ^ sign_i, x_i[2:0]};
  assign ya        = {y_i[3] ^ sign_i, y_i[2:0]};
  assign equal_o   = (x_i == y_i);
  assign greater_o = (xa > ya);
  assign less_o    = (xa < ya);
endmodule

// File: rtl/branch_compare_unit.sv
// Multi-cycle branch-condition resolver: scans operands MSB nibble first and reports taken.
module branch_compare_unit
  import novaedge_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  branch_compare_unit_if.slave bus
);
  localparam int unsigned NIB  = XLEN / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        f3_q, f3_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              rec_q, rec_d, lt_q, lt_d, gt_q, gt_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic              taken_q, taken_d, eq_o_q, eq_o_d, lt_o_q, lt_o_d, gt_o_q, gt_o_d;
  logic              illegal_q, illegal_d;

  logic [NIB-1:0][3:0] x_nibs, y_nibs;
  logic                sign_c, eq_c, gt_c, lt_c;

  assign x_nibs = rs1_q;
  assign y_nibs = rs2_q;
  assign sign_c = (idx_q == IDXW'(NIB - 1)) && f3_q[2] && !f3_q[1];

  nibble_cmp4 u_cmp (
    .x_i       (x_nibs[idx_q]),
    .y_i       (y_nibs[idx_q]),
    .sign_i    (sign_c),
    .equal_o   (eq_c),
    .greater_o (gt_c),
    .less_o    (lt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      f3_q        <= '0;
      idx_q       <= '0;
      rec_q       <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      eq_o_q      <= 1'b0;
      lt_o_q      <= 1'b0;
      gt_o_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      f3_q        <= f3_d;
      idx_q       <= idx_d;
      rec_q       <= rec_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      eq_o_q      <= eq_o_d;
      lt_o_q      <= lt_o_d;
      gt_o_q      <= gt_o_d;
      illegal_q   <= illegal_d;
    end
  end

  // rec_q marks that the first unequal nibble has already fixed lt/gt.
  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    f3_d        = f3_q;
    idx_d       = idx_q;
    rec_d       = rec_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    eq_o_d      = eq_o_q;
    lt_o_d      = lt_o_q;
    gt_o_d      = gt_o_q;
    illegal_d   = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i && in_ready_q) begin
          rs1_d      = bus.rs1_i;
          rs2_d      = bus.rs2_i;
          f3_d       = bus.funct3_i;
          idx_d      = IDXW'(NIB - 1);
          rec_d      = 1'b0;
          lt_d       = 1'b0;
          gt_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!eq_c && !rec_q) begin
          rec_d = 1'b1;
          lt_d  = lt_c;
          gt_d  = gt_c;
        end
        if ((!eq_c && EARLY_EXIT) || (idx_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        // First DONE cycle registers the result; afterwards wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          eq_o_d      = !rec_q;
          lt_o_d      = lt_q;
          gt_o_d      = gt_q;
          taken_d     = branch_taken(f3_q, !rec_q, lt_q, gt_q);
          illegal_d   = is_illegal(f3_q);
        end else if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase

    if (flush_i) begin
      state_d     = ST_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.taken_o     = taken_q;
  assign bus.eq_o        = eq_o_q;
  assign bus.lt_o        = lt_o_q;
  assign bus.gt_o        = gt_o_q;
  assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_branch_compare_unit.sv
// Scoreboard bench: directed branch vectors on an early-exit and a full-scan instance.
module tb_branch_compare_unit;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        eq, lt, gt, tk, il;
    int          lat;
  } vec_t;

  typedef struct {
    logic eq, lt, gt, tk, il;
    int   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        vld = 1'b0;
  logic        rdy = 1'b1;
  logic        sel = 1'b1;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  f3 = '0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t cur[2];
  logic pv[2];
  logic have[2];
  int   acc[2];
  vec_t vt[11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_compare_unit_if #(.XLEN(32)) if0 ();
  branch_compare_unit_if #(.XLEN(32)) if1 ();

  assign if0.in_valid_i  = vld & ~sel;
  assign if1.in_valid_i  = vld & sel;
  assign if0.rs1_i       = rs1;
  assign if1.rs1_i       = rs1;
  assign if0.rs2_i       = rs2;
  assign if1.rs2_i       = rs2;
  assign if0.funct3_i    = f3;
  assign if1.funct3_i    = f3;
  assign if0.out_ready_i = rdy;
  assign if1.out_ready_i = rdy;

  branch_compare_unit #(.XLEN(32), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(if0.slave));
  branch_compare_unit #(.XLEN(32), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(if1.slave));

  task automatic chk(input string name, input int u, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s u%0d: got %0d expected %0d (cycle %0d)", name, u, act, expv, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic eq, input logic lt, input logic gt,
                              input logic tk, input logic il, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.eq = eq; v.lt = lt; v.gt = gt; v.tk = tk; v.il = il;
    v.lat = lat;
    return v;
  endfunction

  // Monitor: pops on the rising edge of out_valid, then checks every held cycle.
  task automatic mon(input int u, input logic v, input logic ir, input logic tk,
                     input logic e, input logic l, input logic g, input logic il);
    if (!rst_n) begin
      pv[u] = 1'b0;
      have[u] = 1'b0;
      return;
    end
    if (v && !pv[u]) begin
      if ((u == 1) ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
        chk("unexpected_out_valid", u, 1, 0);
        have[u] = 1'b0;
      end else begin
        cur[u] = (u == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
        have[u] = 1'b1;
        chk("latency", u, cyc - acc[u], cur[u].lat);
      end
    end
    if (v && have[u]) begin
      chk("eq", u, int'(e), int'(cur[u].eq));
      chk("lt", u, int'(l), int'(cur[u].lt));
      chk("gt", u, int'(g), int'(cur[u].gt));
      chk("taken", u, int'(tk), int'(cur[u].tk));
      chk("illegal", u, int'(il), int'(cur[u].il));
      chk("in_ready_while_valid", u, int'(ir), 0);
    end
    if (!v) have[u] = 1'b0;
    pv[u] = v;
  endtask

  always @(negedge clk)
    mon(0, if0.out_valid_o, if0.in_ready_o, if0.taken_o, if0.eq_o, if0.lt_o, if0.gt_o,
        if0.illegal_o);
  always @(negedge clk)
    mon(1, if1.out_valid_o, if1.in_ready_o, if1.taken_o, if1.eq_o, if1.lt_o, if1.gt_o,
        if1.illegal_o);

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic s, input vec_t v, input bit push);
    exp_t e;
    logic ok;
    bit   got = 0;
    sel = s; f3 = v.f; rs1 = v.a; rs2 = v.b; vld = 1'b1;
    if (push) begin
      e.eq = v.eq; e.lt = v.lt; e.gt = v.gt; e.tk = v.tk; e.il = v.il;
      e.lat = s ? v.lat : 9;
      if (s) exp_q1.push_back(e); else exp_q0.push_back(e);
    end
    for (int i = 0; i < 40; i++) begin
      ok = s ? if1.in_ready_o : if0.in_ready_o;
      @(posedge clk);
      #1;
      if (ok) begin
        acc[s ? 1 : 0] = cyc;
        got = 1;
        break;
      end
    end
    if (!got) chk("accept_timeout", int'(s), 0, 1);
    vld = 1'b0;
  endtask

  task automatic drain(input logic s);
    bit done = 0;
    for (int i = 0; i < 60; i++) begin
      if ((s ? exp_q1.size() : exp_q0.size()) == 0 &&
          (s ? (if1.in_ready_o && !if1.out_valid_o) : (if0.in_ready_o && !if0.out_valid_o))) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("drain_timeout", int'(s), 0, 1);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_in_ready"}, 1, int'(if1.in_ready_o), 1);
    chk({name, "_out_valid"}, 1, int'(if1.out_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    vt[0]  = mk(3'b000, 32'h1234_5678, 32'h1234_5678, 1, 0, 0, 1, 0, 9);
    vt[1]  = mk(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0, 1, 0, 2);
    vt[2]  = mk(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 1, 0, 0, 2);
    vt[3]  = mk(3'b101, 32'h8000_0000, 32'h8000_0000, 1, 0, 0, 1, 0, 9);
    vt[4]  = mk(3'b001, 32'h0000_0010, 32'h0000_0011, 0, 1, 0, 1, 0, 9);
    vt[5]  = mk(3'b010, 32'h0000_0005, 32'h0000_0003, 0, 0, 1, 0, 1, 9);
    vt[6]  = mk(3'b111, 32'h0010_0000, 32'h000F_FFFF, 0, 0, 1, 1, 0, 4);
    vt[7]  = mk(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 1, 1, 0, 2);
    vt[8]  = mk(3'b001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 9);
    vt[9]  = mk(3'b100, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 1, 0, 1, 0, 9);
    vt[10] = mk(3'b011, 32'hCAFE_0001, 32'hCAFE_0001, 1, 0, 0, 0, 1, 9);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 1, int'(if1.in_ready_o), 1);
    chk("rst_out_valid", 1, int'(if1.out_valid_o), 0);
    chk("rst_taken", 1, int'(if1.taken_o), 0);
    chk("rst_flags", 1, int'({if1.eq_o, if1.lt_o, if1.gt_o, if1.illegal_o}), 0);
    chk("rst_in_ready", 0, int'(if0.in_ready_o), 1);
    chk("rst_out_valid", 0, int'(if0.out_valid_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      issue(1'b1, vt[i], 1);
      drain(1'b1);
    end
    for (int i = 0; i < 11; i++) begin
      issue(1'b0, vt[i], 1);
      drain(1'b0);
    end

    // Back-pressure: result held five cycles while a competing request is offered.
    rdy = 1'b0;
    issue(1'b1, vt[1], 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (if1.out_valid_o) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_valid_seen", 1, int'(seen), 1);
    sel = 1'b1; f3 = vt[0].f; rs1 = vt[0].a; rs2 = vt[0].b; vld = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    rdy = 1'b1;
    drain(1'b1);

    // Flush in the third BUSY cycle: no result may appear.
    issue(1'b1, vt[0], 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk_idle("flush");
    repeat (12) begin
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-scan.
    issue(1'b1, vt[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk_idle("midrst");
    chk("midrst_eq", 1, int'(if1.eq_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, vt[6], 1);
    drain(1'b1);
    issue(1'b1, vt[4], 1);
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
